// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the four-way round-robin mux arbiter.
package mux4_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 8;

  // IDLE: nobody owns the datapath. OWN: requester sel owns it.
  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

endpackage : mux4_arb_pkg

// File: rtl/mux4.sv
// Plain 4:1 mux datapath; s1 is the high select bit, s2 the low one.
module mux4 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             s1,
  input  logic             s2,
  output logic [WIDTH-1:0] y
);

  // Two-level select tree.
  always_comb begin
    case ({s1, s2})
      2'b00:   y = d0;
      2'b01:   y = d1;
      2'b10:   y = d2;
      default: y = d3;
    endcase
  end

endmodule : mux4

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit scanning
// ptr+1, ptr+2, ptr+3, ptr (mod 4). The last-served index comes last.
module rr_pick
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  // Scan the four rotated positions and keep the first hit.
  always_comb begin
    logic [SEL_W-1:0] cand;
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      // Two-bit addition wraps naturally; offset 4 lands back on ptr.
      cand = ptr + SEL_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule : rr_pick

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters, with a
// valid/ready output, per-beat acknowledge and a per-grant beat cap.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [WIDTH-1:0]   d0,
  input  logic [WIDTH-1:0]   d1,
  input  logic [WIDTH-1:0]   d2,
  input  logic [WIDTH-1:0]   d3,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] in_ack,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               busy
);

  // Beat index of the last beat a single grant may carry.
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;

  logic               owner_req;
  logic               transfer;
  logic               release_own;
  logic               arbitrate;
  logic [SEL_W-1:0]   pick_ptr;
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;

  // Handshake and release decode for the current owner.
  always_comb begin
    owner_req   = req[sel_q];
    out_valid   = (state_q == OWN) && owner_req;
    transfer    = out_valid && out_ready;
    in_ack      = {NUM_REQ{transfer}} & grant_q;
    release_own = (state_q == OWN) &&
                  (!owner_req || (transfer && (cnt_q == LAST_BEAT)));
    arbitrate   = (state_q == IDLE) || release_own;
    // On release the owner becomes the new last-served index this cycle,
    // so the scan already places it last.
    pick_ptr    = (state_q == OWN) ? sel_q : ptr_q;
  end

  rr_pick u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state logic: grant hand-over, idle fallback and beat counting.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (arbitrate) begin
      ptr_d = pick_ptr;
      cnt_d = '0;
      if (pick_found) begin
        state_d = OWN;
        sel_d   = pick_idx;
        grant_d = NUM_REQ'(1) << pick_idx;
      end else begin
        // sel is kept so the idle mux output stays where it was.
        state_d = IDLE;
        grant_d = '0;
      end
    end else if (transfer) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= SEL_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign busy  = (state_q == OWN);

  mux4 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .d0 (d0),
    .d1 (d1),
    .d2 (d2),
    .d3 (d3),
    .s1 (sel_q[1]),
    .s2 (sel_q[0]),
    .y  (out_data)
  );

endmodule : mux4_rr_arbiter

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios followed by
// random traffic, all compared against a cycle-level reference model.
module tb_mux4_rr_arbiter;

  localparam int WIDTH     = 8;
  localparam int MAX_BEATS = 4;

  logic             clk;
  logic             reset;
  logic [3:0]       req;
  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       in_ack;
  logic [3:0]       grant;
  logic [1:0]       sel;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  // Reference model state: owner index (-1 when idle), last served, beats.
  int m_owner;
  int m_ptr;
  int m_cnt;
  int m_sel;

  mux4_rr_arbiter #(
    .WIDTH     (WIDTH),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .in_ack    (in_ack),
    .grant     (grant),
    .sel       (sel),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] data_of(int i);
    case (i)
      0:       return d0;
      1:       return d1;
      2:       return d2;
      default: return d3;
    endcase
  endfunction

  // First requester after 'from' in circular order; -1 if none.
  function automatic int pick(logic [3:0] r, int from);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (from + k) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare every output against the model's view of the current cycle.
  task automatic compare_outputs(string tag);
    logic        e_valid;
    logic [3:0]  e_ack;
    logic [3:0]  e_grant;
    logic [WIDTH-1:0] e_data;
    if (m_owner < 0) begin
      e_valid = 1'b0;
      e_ack   = 4'b0000;
      e_grant = 4'b0000;
    end else begin
      e_valid = req[m_owner];
      e_ack   = (e_valid && out_ready) ? 4'(1 << m_owner) : 4'b0000;
      e_grant = 4'(1 << m_owner);
    end
    e_data = data_of(m_sel);
    chk({tag, ".grant"},     32'(grant),     32'(e_grant));
    chk({tag, ".busy"},      32'(busy),      32'(m_owner >= 0));
    chk({tag, ".sel"},       32'(sel),       32'(m_sel));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
    chk({tag, ".in_ack"},    32'(in_ack),    32'(e_ack));
    chk({tag, ".out_data"},  32'(out_data),  32'(e_data));
  endtask

  // Advance the model across one rising edge using the held inputs.
  task automatic model_edge();
    int  w;
    bit  xfer;
    if (!reset) begin
      m_owner = -1;
      m_sel   = 0;
      m_ptr   = 3;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_sel   = w;
        m_cnt   = 0;
      end
    end else begin
      xfer = req[m_owner] && out_ready;
      if (!req[m_owner] || (xfer && (m_cnt + 1 == MAX_BEATS))) begin
        m_ptr   = m_owner;
        w       = pick(req, m_owner);
        m_owner = w;
        if (w >= 0) m_sel = w;
        m_cnt   = 0;
      end else if (xfer) begin
        m_cnt++;
      end
    end
  endtask

  // One clock: check at the falling edge, then step DUT and model together.
  task automatic cycle(string tag);
    @(negedge clk);
    compare_outputs(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b1;
    d0 = 8'hA0; d1 = 8'hB1; d2 = 8'hC2; d3 = 8'hD3;
    repeat (2) @(posedge clk);
    m_owner = -1; m_sel = 0; m_ptr = 3; m_cnt = 0;
    #1;

    // Idle after reset with no requests.
    reset = 1'b1;
    for (int i = 0; i < 5; i++) cycle("idle");

    // Requesters 0 and 2 alternate in MAX_BEATS bursts.
    req = 4'b0101;
    for (int i = 0; i < 12; i++) cycle("rr02");
    req = 4'b0000;
    for (int i = 0; i < 3; i++) cycle("drain");

    // Owner 1 stalled by downstream for three cycles.
    req = 4'b0010;
    cycle("own1_grant");
    cycle("own1_beat");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle("own1_stall");
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle("own1_resume");
    req = 4'b0000;
    cycle("drain1");

    // Owner 3 drops its request after two beats while 0 and 1 wait.
    req = 4'b1000;
    cycle("own3_grant");
    cycle("own3_beat0");
    cycle("own3_beat1");
    req = 4'b0011;
    cycle("own3_drop");
    cycle("own3_next");
    req = 4'b0000;
    for (int i = 0; i < 2; i++) cycle("drain3");

    // Reset asserted mid-grant, then all four request together.
    req = 4'b0010;
    cycle("rst_grant");
    cycle("rst_beat0");
    cycle("rst_beat1");
    req   = 4'b1111;
    reset = 1'b0;
    cycle("rst_assert");
    reset = 1'b1;
    cycle("rst_idle");
    cycle("rst_first");
    for (int i = 0; i < 8; i++) cycle("rst_rotate");

    // Random traffic: sticky requests, random backpressure and data.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      d0 = 8'($urandom); d1 = 8'($urandom);
      d2 = 8'($urandom); d3 = 8'($urandom);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mux4_rr_arbiter
